// File: rtl/axi4_master_device_if.sv
// AXI4 bus bundle between a traffic-generator master and a slave.
// Read/write address, data and response channels with master/slave modports.
interface axi4_master_device_if #(
    parameter int unsigned IDW = 4
);
    logic           awvalid;
    logic           awready;
    logic [IDW-1:0] awid;
    logic [31:0]    awaddr;
    logic [7:0]     awlen;
    logic [2:0]     awsize;
    logic [1:0]     awburst;

    logic           wvalid;
    logic           wready;
    logic [63:0]    wdata;
    logic [7:0]     wstrb;
    logic           wlast;

    logic           bvalid;
    logic           bready;
    logic [IDW-1:0] bid;
    logic [1:0]     bresp;

    logic           arvalid;
    logic           arready;
    logic [IDW-1:0] arid;
    logic [31:0]    araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;

    logic           rvalid;
    logic           rready;
    logic [IDW-1:0] rid;
    logic [63:0]    rdata;
    logic [1:0]     rresp;
    logic           rlast;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/axi4_master_device.sv
// Directed AXI4 master: one 8-beat INCR write of BASE+i, one 8-beat read captured into rdata[].
// Define AXI4_MASTER_RESP_CHECK_EN to enable the sticky resp_err response/ID checker.
module axi4_master_device #(
    parameter int unsigned    IDW   = 4,
    parameter logic [IDW-1:0] ID    = '0,
    parameter int unsigned    DEPTH = 16,
    parameter logic [63:0]    BASE  = 64'hdeadbeefdeadbeef
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start_write,
    input  logic                 start_read,
    input  logic [31:0]          addr,
    output logic                 write_busy,
    output logic                 read_busy,
    output logic                 write_done,
    output logic                 read_done,
    output logic                 resp_err,
    axi4_master_device_if.master axi
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {WiIdle, WAddr, WData, WResp} wr_state_e;
    typedef enum logic [1:0] {RiIdle, RAddr, RData} rd_state_e;

    wr_state_e         wr_state_q, wr_state_d;
    rd_state_e         rd_state_q, rd_state_d;
    logic [2:0]        beat_q;
    logic [31:0]       awaddr_q;
    logic [31:0]       araddr_q;
    logic [PW-1:0]     rptr_q;
    logic [63:0]       rdata [DEPTH];
    logic              r_hs;

    // State registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_state_q <= WiIdle;
            rd_state_q <= RiIdle;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            WiIdle:  if (start_write) wr_state_d = WAddr;
            WAddr:   if (axi.awready) wr_state_d = WData;
            WData:   if (axi.wready && beat_q == 3'd7) wr_state_d = WResp;
            WResp:   if (axi.bvalid) wr_state_d = WiIdle;
            default: wr_state_d = WiIdle;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            RiIdle:  if (start_read) rd_state_d = RAddr;
            RAddr:   if (axi.arready) rd_state_d = RData;
            // rlast terminates the burst even if fewer than 8 beats arrived
            RData:   if (axi.rvalid && axi.rlast) rd_state_d = RiIdle;
            default: rd_state_d = RiIdle;
        endcase
    end

    always_comb begin
        axi.awvalid = (wr_state_q == WAddr);
        axi.awid    = ID;
        axi.awaddr  = awaddr_q;
        axi.awlen   = 8'd7;
        axi.awsize  = 3'd3;
        axi.awburst = 2'b01;
        axi.wvalid  = (wr_state_q == WData);
        axi.wdata   = BASE + {61'd0, beat_q};
        axi.wstrb   = 8'hFF;
        axi.wlast   = (beat_q == 3'd7);
        axi.bready  = (wr_state_q == WResp);
        write_busy  = (wr_state_q != WiIdle);
        write_done  = (wr_state_q == WResp) && axi.bvalid;
    end

    always_comb begin
        axi.arvalid = (rd_state_q == RAddr);
        axi.arid    = ID;
        axi.araddr  = araddr_q;
        axi.arlen   = 8'd7;
        axi.arsize  = 3'd3;
        axi.arburst = 2'b01;
        axi.rready  = (rd_state_q == RData);
        r_hs        = (rd_state_q == RData) && axi.rvalid;
        read_busy   = (rd_state_q != RiIdle);
        read_done   = r_hs && axi.rlast;
    end

    // Burst datapath and read-capture array
    always_ff @(posedge CLK) begin
        if (RST) begin
            beat_q   <= '0;
            awaddr_q <= '0;
            araddr_q <= '0;
            rptr_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) rdata[i] <= '0;
        end else begin
            if (wr_state_q == WiIdle && start_write) begin
                awaddr_q <= addr;
                beat_q   <= '0;
            end else if (axi.wvalid && axi.wready) begin
                beat_q <= beat_q + 3'd1;
            end
            if (rd_state_q == RiIdle && start_read) begin
                araddr_q <= addr;
                rptr_q   <= addr[PW-1:0];
            end else if (r_hs) begin
                rdata[rptr_q] <= axi.rdata;
                rptr_q        <= rptr_q + PW'(1);
            end
        end
    end

`ifdef AXI4_MASTER_RESP_CHECK_EN
    logic resp_err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            resp_err_q <= 1'b0;
        end else if ((write_done && (axi.bresp != 2'b00 || axi.bid != ID)) ||
                     (r_hs && (axi.rresp != 2'b00 || axi.rid != ID))) begin
            resp_err_q <= 1'b1;
        end
    end

    assign resp_err = resp_err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{axi.bid, axi.bresp, axi.rid, axi.rresp};
    assign resp_err    = 1'b0;
`endif
endmodule

// File: tb/tb_axi4_master_device.sv
// Bench for axi4_master_device: reactive slave plus protocol-level model checked every cycle.
`timescale 1ns/1ps
module tb_axi4_master_device;
    localparam logic [63:0] BASE  = 64'hdeadbeefdeadbeef;
    localparam int          DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start_write = 1'b0;
    logic        start_read = 1'b0;
    logic [31:0] addr = '0;
    logic        write_busy, read_busy, write_done, read_done, resp_err;

    axi4_master_device_if #(.IDW(4)) axi ();

    axi4_master_device dut (
        .CLK         (CLK),
        .RST         (RST),
        .start_write (start_write),
        .start_read  (start_read),
        .addr        (addr),
        .write_busy  (write_busy),
        .read_busy   (read_busy),
        .write_done  (write_done),
        .read_done   (read_done),
        .resp_err    (resp_err),
        .axi         (axi)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    // Model of what the master must be doing
    logic        w_active = 0, aw_done = 0, r_active = 0, ar_done = 0, b_pending = 0, err_exp = 0;
    int          w_beats = 0, rk = 0, r_left = 0;
    logic [31:0] exp_waddr = '0, exp_raddr = '0;
    logic [63:0] exp_rdata [DEPTH];

    // Slave knobs and wait counters
    int          aw_stall = 0, w_stall = 0, ar_stall = 0, r_beats_cfg = 8;
    logic [1:0]  b_resp_cfg = 2'b00;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;

    // Transaction records
    int          aw_count = 0, w_count = 0, wdone_count = 0, rdone_count = 0;
    logic [31:0] last_awaddr = '0;
    logic [63:0] last_wdata = '0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Slave driver + model + per-cycle compare
    initial begin
        for (int i = 0; i < DEPTH; i++) exp_rdata[i] = '0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bid = '0; axi.bresp = '0;
        axi.arready = 0; axi.rvalid = 0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0;
        axi.rlast = 0;
        forever begin
            @(negedge CLK);
            if (axi.awvalid) begin axi.awready = (aw_wait >= aw_stall); aw_wait++; end
            else begin axi.awready = 0; aw_wait = 0; end
            if (axi.wvalid) begin
                axi.wready = (w_wait >= w_stall) && (w_wait != w_stall + 3);
                w_wait++;
            end else begin axi.wready = 0; w_wait = 0; end
            axi.bvalid = b_pending;
            axi.bresp  = b_resp_cfg;
            if (axi.arvalid) begin axi.arready = (ar_wait >= ar_stall); ar_wait++; end
            else begin axi.arready = 0; ar_wait = 0; end
            axi.rvalid = (r_left > 0);
            axi.rlast  = (r_left == 1);
            axi.rdata  = BASE + 64'(exp_raddr) + 64'(rk) - 64'd3;
            #1;
            if (RST) begin
                w_active = 0; aw_done = 0; r_active = 0; ar_done = 0; b_pending = 0;
                err_exp = 0; w_beats = 0; rk = 0; r_left = 0;
                for (int i = 0; i < DEPTH; i++) exp_rdata[i] = '0;
            end else begin
                chk("write_busy", write_busy, w_active);
                chk("read_busy", read_busy, r_active);
                chk("awvalid", axi.awvalid, w_active && !aw_done);
                if (axi.awvalid) begin
                    chk("awaddr", axi.awaddr, exp_waddr);
                    chk("awlen", axi.awlen, 7);
                    chk("awsize", axi.awsize, 3);
                    chk("awburst", axi.awburst, 1);
                    chk("awid", axi.awid, 0);
                end
                chk("wvalid", axi.wvalid, w_active && aw_done && w_beats < 8);
                if (axi.wvalid) begin
                    chk("wdata", axi.wdata, BASE + 64'(w_beats));
                    chk("wlast", axi.wlast, w_beats == 7);
                    chk("wstrb", axi.wstrb, 8'hFF);
                end
                chk("bready", axi.bready, w_active && w_beats == 8);
                chk("write_done", write_done, w_active && w_beats == 8 && axi.bvalid);
                chk("arvalid", axi.arvalid, r_active && !ar_done);
                if (axi.arvalid) begin
                    chk("araddr", axi.araddr, exp_raddr);
                    chk("arlen", axi.arlen, 7);
                    chk("arsize", axi.arsize, 3);
                    chk("arburst", axi.arburst, 1);
                    chk("arid", axi.arid, 0);
                end
                chk("rready", axi.rready, r_active && ar_done);
                chk("read_done", read_done, r_active && ar_done && axi.rvalid && axi.rlast);
                chk("resp_err", resp_err, err_exp);

                if (axi.awvalid && axi.awready) begin aw_count++; last_awaddr = axi.awaddr; end
                if (axi.wvalid && axi.wready) begin w_count++; last_wdata = axi.wdata; end
                if (write_done) wdone_count++;
                if (read_done) rdone_count++;

                if (!w_active) begin
                    if (start_write) begin
                        w_active = 1; aw_done = 0; w_beats = 0; exp_waddr = addr;
                    end
                end else begin
                    if (axi.awvalid && axi.awready) aw_done = 1;
                    if (axi.wvalid && axi.wready) begin
                        w_beats++;
                        if (w_beats == 8) b_pending = 1;
                    end
                    if (axi.bvalid && axi.bready) begin
                        w_active = 0; b_pending = 0;
`ifdef AXI4_MASTER_RESP_CHECK_EN
                        if (axi.bresp != 2'b00 || axi.bid != 4'd0) err_exp = 1;
`endif
                    end
                end

                if (!r_active) begin
                    if (start_read) begin
                        r_active = 1; ar_done = 0; rk = 0; exp_raddr = addr;
                    end
                end else begin
                    if (axi.arvalid && axi.arready) begin ar_done = 1; r_left = r_beats_cfg; end
                    if (axi.rvalid && axi.rready) begin
                        exp_rdata[int'((exp_raddr + 32'(rk)) % 32'(DEPTH))] = axi.rdata;
                        rk++;
                        r_left--;
`ifdef AXI4_MASTER_RESP_CHECK_EN
                        if (axi.rresp != 2'b00 || axi.rid != 4'd0) err_exp = 1;
`endif
                        if (axi.rlast) begin r_active = 0; r_left = 0; end
                    end
                end
            end
        end
    end

    task automatic pulse(input logic w, input logic r, input logic [31:0] a);
        @(negedge CLK);
        start_write = w; start_read = r; addr = a;
        @(negedge CLK);
        start_write = 0; start_read = 0;
        #2;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((w_active || r_active) && n < 200) begin @(negedge CLK); #2; n++; end
        total++;
        if (w_active || r_active) begin
            bad++;
            $display("FAIL timeout_%s: still busy after %0d cycles, required idle", nm, n);
        end
        repeat (2) @(negedge CLK);
        #2;
    endtask

    task automatic check_rdata(input string nm);
        for (int i = 0; i < DEPTH; i++) chk(nm, dut.rdata[i], exp_rdata[i]);
    endtask

    int aw0, w0, wd0, rd0;

    task automatic snap();
        aw0 = aw_count; w0 = w_count; wd0 = wdone_count; rd0 = rdone_count;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        RST = 0;
        #2;
        chk("rst_write_busy", write_busy, 0);
        chk("rst_read_busy", read_busy, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_rdata0", dut.rdata[0], 0);

        // Plain write at addr 2
        snap();
        pulse(1, 0, 32'd2);
        wait_idle("write2");
        chk("w2_aw_count", aw_count - aw0, 1);
        chk("w2_awaddr", last_awaddr, 32'd2);
        chk("w2_beats", w_count - w0, 8);
        chk("w2_last_wdata", last_wdata, 64'hdeadbeefdeadbef6);
        chk("w2_done_count", wdone_count - wd0, 1);

        // Plain read at addr 3
        snap();
        pulse(0, 1, 32'd3);
        wait_idle("read3");
        chk("r3_done_count", rdone_count - rd0, 1);
        chk("r3_rdata3", dut.rdata[3], 64'hdeadbeefdeadbeef);
        chk("r3_rdata10", dut.rdata[10], 64'hdeadbeefdeadbef6);
        chk("r3_rdata2", dut.rdata[2], 0);
        chk("r3_rdata11", dut.rdata[11], 0);
        check_rdata("r3_array");

        // Back-pressure on AW and W
        aw_stall = 5; w_stall = 5;
        snap();
        pulse(1, 0, 32'd40);
        wait_idle("stall");
        chk("bp_aw_count", aw_count - aw0, 1);
        chk("bp_beats", w_count - w0, 8);
        chk("bp_last_wdata", last_wdata, 64'hdeadbeefdeadbef6);
        chk("bp_done_count", wdone_count - wd0, 1);
        aw_stall = 0; w_stall = 0;

        // Concurrent write and wrapping read
        ar_stall = 2;
        snap();
        pulse(1, 1, 32'd13);
        wait_idle("concurrent");
        chk("cc_beats", w_count - w0, 8);
        chk("cc_wdone", wdone_count - wd0, 1);
        chk("cc_rdone", rdone_count - rd0, 1);
        chk("cc_rdata0", dut.rdata[0], 64'hdeadbeefdeadbefc);
        chk("cc_rdata3", dut.rdata[3], 64'hdeadbeefdeadbeff);
        check_rdata("cc_array");
        ar_stall = 0;

        // Second start while busy must be ignored
        snap();
        pulse(1, 0, 32'd50);
        pulse(1, 0, 32'd99);
        wait_idle("busy_start");
        chk("bs_aw_count", aw_count - aw0, 1);
        chk("bs_awaddr", last_awaddr, 32'd50);
        chk("bs_wdone", wdone_count - wd0, 1);

        // Early rlast after 3 beats
        r_beats_cfg = 3;
        snap();
        pulse(0, 1, 32'd6);
        wait_idle("early_rlast");
        chk("er_rdone", rdone_count - rd0, 1);
        chk("er_rdata6", dut.rdata[6], 64'hdeadbeefdeadbef2);
        chk("er_rdata8", dut.rdata[8], 64'hdeadbeefdeadbef4);
        check_rdata("er_array");
        r_beats_cfg = 8;

        // Error response, then a clean write
        b_resp_cfg = 2'b10;
        pulse(1, 0, 32'd1);
        wait_idle("bresp_err");
        b_resp_cfg = 2'b00;
        pulse(1, 0, 32'd4);
        wait_idle("after_err");
`ifdef AXI4_MASTER_RESP_CHECK_EN
        chk("resp_err_sticky", resp_err, 1);
`else
        chk("resp_err_off", resp_err, 0);
`endif

        // Reset in the middle of the W phase
        pulse(1, 0, 32'd30);
        begin
            int n = 0;
            while (w_beats < 3 && n < 50) begin @(negedge CLK); #2; n++; end
            chk("mid_reached_beat3", w_beats >= 3, 1);
        end
        @(negedge CLK);
        RST = 1;
        @(negedge CLK);
        RST = 0;
        #2;
        chk("mr_awvalid", axi.awvalid, 0);
        chk("mr_wvalid", axi.wvalid, 0);
        chk("mr_write_busy", write_busy, 0);
        chk("mr_read_busy", read_busy, 0);
        chk("mr_resp_err", resp_err, 0);
        chk("mr_rdata3", dut.rdata[3], 0);
        check_rdata("mr_array");

        // Fresh burst after reset
        snap();
        pulse(1, 0, 32'd20);
        wait_idle("fresh");
        chk("fr_aw_count", aw_count - aw0, 1);
        chk("fr_awaddr", last_awaddr, 32'd20);
        chk("fr_beats", w_count - w0, 8);
        chk("fr_last_wdata", last_wdata, 64'hdeadbeefdeadbef6);
        chk("fr_wdone", wdone_count - wd0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
